// File: rtl/leaf_out_arbiter_if.sv
// rtl/leaf_out_arbiter_if.sv - user-stream, config, credit and BFT link signals of the leaf output arbiter
interface leaf_out_arbiter_if #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_OUT_PORTS = 7
);
  logic                                  resend;
  logic                                  bft_ready;
  logic                                  cfg_we;
  logic [NUM_PORT_BITS-1:0]              cfg_port;
  logic [NUM_LEAF_BITS-1:0]              cfg_leaf;
  logic [NUM_PORT_BITS-1:0]              cfg_dport;
  logic                                  credit_vld;
  logic [NUM_PORT_BITS-1:0]              credit_port;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user;
  logic [NUM_OUT_PORTS-1:0]              vld_user;
  logic [NUM_OUT_PORTS-1:0]              ack_user;
  logic [PACKET_BITS-1:0]                dout;
  logic [NUM_PORT_BITS-1:0]              grant_idx;

  modport master (
    output resend, bft_ready, cfg_we, cfg_port, cfg_leaf, cfg_dport,
    output credit_vld, credit_port, din_user, vld_user,
    input  ack_user, dout, grant_idx
  );

  modport slave (
    input  resend, bft_ready, cfg_we, cfg_port, cfg_leaf, cfg_dport,
    input  credit_vld, credit_port, din_user, vld_user,
    output ack_user, dout, grant_idx
  );
endinterface

// File: rtl/leaf_out_arbiter.sv
// rtl/leaf_out_arbiter.sv - round-robin, credit-gated arbiter of user output streams onto the leaf-to-BFT link
module leaf_out_arbiter #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 7,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input logic               clk,
  input logic               reset,
  leaf_out_arbiter_if.slave bus
);

  localparam int CRED_W   = NUM_BRAM_ADDR_BITS + 1;
  localparam int CRED_MAX = 1 << NUM_BRAM_ADDR_BITS;
  localparam int VLD_BIT  = PACKET_BITS - 1;

  logic [NUM_OUT_PORTS-1:0] cfg_q, cfg_d;
  logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] leaf_d   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_q  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_d  [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_d   [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit_q [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit_d [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] ptr_q, ptr_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [NUM_PORT_BITS-1:0] gidx_q, gidx_d;

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] ack;
  logic                     can_grant;
  logic                     found;
  logic                     grant;
  logic                     found_hi;
  logic [NUM_PORT_BITS-1:0] win_hi;
  logic [NUM_PORT_BITS-1:0] win_lo;
  logic [NUM_PORT_BITS-1:0] winner;
  logic [PACKET_BITS-1:0]   pkt;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = bus.vld_user[i] & cfg_q[i] & (credit_q[i] != '0);
    end
  end

  // A held (unaccepted) packet blocks new grants; resend blocks everything.
  assign can_grant = !bus.resend && (bus.bft_ready || !dout_q[VLD_BIT]);
  assign found     = |eligible;
  assign grant     = can_grant && found;

  // Round-robin: lowest eligible index at or above the pointer, else lowest overall.
  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = NUM_OUT_PORTS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_lo = NUM_PORT_BITS'(i);
        if (i >= int'(ptr_q)) begin
          found_hi = 1'b1;
          win_hi   = NUM_PORT_BITS'(i);
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    ack = '0;
    pkt = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (winner == NUM_PORT_BITS'(i)) begin
        ack[i] = grant;
        pkt    = {1'b1, leaf_q[i], dport_q[i], addr_q[i],
                  bus.din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
    end
  end

  always_comb begin
    dout_d = '0;
    gidx_d = gidx_q;
    ptr_d  = ptr_q;
    if (bus.resend) begin
      dout_d = '0;
    end else if (grant) begin
      dout_d = pkt;
      gidx_d = winner;
      ptr_d  = (winner == NUM_PORT_BITS'(NUM_OUT_PORTS - 1)) ? '0 : winner + 1'b1;
    end else if (!bus.bft_ready && dout_q[VLD_BIT]) begin
      dout_d = dout_q;
    end
  end

  // Config writes take effect next edge, so a same-cycle grant still sees the old destination.
  always_comb begin
    int c;
    cfg_d = cfg_q;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      leaf_d[i]  = leaf_q[i];
      dport_d[i] = dport_q[i];
      addr_d[i]  = addr_q[i];
      c          = int'(credit_q[i]);
      if (bus.cfg_we && bus.cfg_port == NUM_PORT_BITS'(i)) begin
        cfg_d[i]   = 1'b1;
        leaf_d[i]  = bus.cfg_leaf;
        dport_d[i] = bus.cfg_dport;
      end
      if (grant && winner == NUM_PORT_BITS'(i)) begin
        addr_d[i] = addr_q[i] + 1'b1;
        c         = c - 1;
      end
      if (bus.credit_vld && bus.credit_port == NUM_PORT_BITS'(i)) begin
        c = c + FREESPACE_UPDATE_SIZE;
      end
      if (c > CRED_MAX) begin
        c = CRED_MAX;
      end
      credit_d[i] = CRED_W'(c);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q  <= '0;
      ptr_q  <= '0;
      dout_q <= '0;
      gidx_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]   <= '0;
        dport_q[i]  <= '0;
        addr_q[i]   <= '0;
        credit_q[i] <= CRED_W'(CRED_MAX);
      end
    end else begin
      cfg_q  <= cfg_d;
      ptr_q  <= ptr_d;
      dout_q <= dout_d;
      gidx_q <= gidx_d;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]   <= leaf_d[i];
        dport_q[i]  <= dport_d[i];
        addr_q[i]   <= addr_d[i];
        credit_q[i] <= credit_d[i];
      end
    end
  end

  assign bus.ack_user  = ack;
  assign bus.dout      = dout_q;
  assign bus.grant_idx = gidx_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb/tb_leaf_out_arbiter.sv - directed and random bench for leaf_out_arbiter against a behavioural model
module tb_leaf_out_arbiter;

  localparam int N = 7;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  leaf_out_arbiter_if bus ();

  leaf_out_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pl [N];
  int          m_credit [N];
  int          m_addr   [N];
  int          m_cfg    [N];
  int          m_leaf   [N];
  int          m_dport  [N];
  int          m_ptr;
  int          m_gidx;
  logic [48:0] m_dout;
  logic [6:0]  seen_ack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_credit[i] = 128;
      m_addr[i]   = 0;
      m_cfg[i]    = 0;
      m_leaf[i]   = 0;
      m_dport[i]  = 0;
    end
    m_ptr  = 0;
    m_gidx = 0;
    m_dout = '0;
  endtask

  function automatic int model_winner();
    if (bus.resend || (!bus.bft_ready && m_dout[48])) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (bus.vld_user[i] && m_cfg[i] != 0 && m_credit[i] > 0) return i;
    end
    return -1;
  endfunction

  task automatic model_update(input int w);
    int p;
    if (bus.resend) begin
      m_dout = '0;
    end else if (w >= 0) begin
      m_dout      = {1'b1, 5'(m_leaf[w]), 4'(m_dport[w]), 7'(m_addr[w]), pl[w]};
      m_gidx      = w;
      m_addr[w]   = (m_addr[w] + 1) % 128;
      m_credit[w] = m_credit[w] - 1;
      m_ptr       = (w + 1) % N;
    end else if (!(!bus.bft_ready && m_dout[48])) begin
      m_dout = '0;
    end
    p = int'(bus.credit_port);
    if (bus.credit_vld && p < N) begin
      m_credit[p] = (m_credit[p] + 64 > 128) ? 128 : m_credit[p] + 64;
    end
    p = int'(bus.cfg_port);
    if (bus.cfg_we && p < N) begin
      m_cfg[p]   = 1;
      m_leaf[p]  = int'(bus.cfg_leaf);
      m_dport[p] = int'(bus.cfg_dport);
    end
  endtask

  task automatic apply_payload();
    bus.din_user = {pl[6], pl[5], pl[4], pl[3], pl[2], pl[1], pl[0]};
  endtask

  // One clock: ack checked mid-cycle, registered outputs checked just after the edge.
  task automatic cycle();
    int         w;
    logic [6:0] exp_ack;
    apply_payload();
    @(negedge clk);
    w        = model_winner();
    exp_ack  = (w >= 0) ? 7'(1 << w) : 7'd0;
    seen_ack = bus.ack_user;
    chk("ack_user", seen_ack, exp_ack);
    @(posedge clk);
    model_update(w);
    #1;
    chk("dout", bus.dout, m_dout);
    chk("grant_idx", bus.grant_idx, m_gidx);
  endtask

  task automatic cfg(input int port, input int leaf, input int dport);
    bus.cfg_we    = 1'b1;
    bus.cfg_port  = 4'(port);
    bus.cfg_leaf  = 5'(leaf);
    bus.cfg_dport = 4'(dport);
    cycle();
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    int         exp_seq [6];
    int         nacks;
    logic [48:0] held;

    checks = 0;
    errors = 0;
    exp_seq = '{3, 6, 0, 3, 6, 0};
    for (int i = 0; i < N; i++) pl[i] = 32'h0;
    bus.resend      = 1'b0;
    bus.bft_ready   = 1'b1;
    bus.cfg_we      = 1'b0;
    bus.cfg_port    = '0;
    bus.cfg_leaf    = '0;
    bus.cfg_dport   = '0;
    bus.credit_vld  = 1'b0;
    bus.credit_port = '0;
    bus.vld_user    = '0;
    apply_payload();
    model_reset();
    reset = 1'b0;

    #12;
    chk("reset_dout", bus.dout, 49'd0);
    chk("reset_ack", bus.ack_user, 7'd0);
    chk("reset_grant_idx", bus.grant_idx, 4'd0);
    reset = 1'b1;

    // Single stream: packet format and address increment.
    cfg(2, 5, 3);
    bus.vld_user = 7'b0000100;
    pl[2] = 32'hDEADBEEF;
    cycle();
    chk("first_ack", seen_ack, 7'h04);
    chk("first_pkt", bus.dout, {1'b1, 5'd5, 4'd3, 7'd0, 32'hDEADBEEF});
    pl[2] = 32'h12345678;
    cycle();
    chk("second_addr", bus.dout[38:32], 7'd1);
    bus.vld_user = '0;

    // Round-robin fairness over streams 0, 3, 6.
    cfg(0, 1, 1);
    cfg(3, 17, 9);
    cfg(6, 31, 15);
    bus.vld_user = 7'b1001001;
    for (int k = 0; k < 6; k++) begin
      pl[0] = $urandom; pl[3] = $urandom; pl[6] = $urandom;
      cycle();
      chk("rr_seq", bus.grant_idx, 4'(exp_seq[k]));
    end
    bus.vld_user = '0;

    // Credit exhaustion, replenish and address wrap on stream 1.
    cfg(1, 9, 2);
    bus.vld_user = 7'b0000010;
    nacks = 0;
    for (int k = 0; k < 128; k++) begin
      pl[1] = $urandom;
      cycle();
      if (seen_ack[1]) nacks++;
    end
    chk("credit_128_acks", nacks, 128);
    chk("last_addr_127", bus.dout[38:32], 7'd127);
    cycle();
    chk("no_credit_ack", seen_ack, 7'd0);
    bus.credit_vld  = 1'b1;
    bus.credit_port = 4'd1;
    cycle();
    bus.credit_vld = 1'b0;
    nacks = 0;
    for (int k = 0; k < 64; k++) begin
      pl[1] = $urandom;
      cycle();
      if (k == 0) chk("addr_wrap_0", bus.dout[38:32], 7'd0);
      if (seen_ack[1]) nacks++;
    end
    chk("credit_64_acks", nacks, 64);
    cycle();
    chk("credit_out_again", seen_ack, 7'd0);
    bus.vld_user = '0;

    // Backpressure: held packet stays stable.
    bus.vld_user = 7'b0000001;
    pl[0] = 32'hA5A5_0001;
    cycle();
    held = bus.dout;
    bus.bft_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pl[0] = $urandom;
      cycle();
      chk("stall_ack", seen_ack, 7'd0);
      chk("stall_dout", bus.dout, held);
    end
    bus.bft_ready = 1'b1;
    cycle();
    chk("stall_resume_ack", seen_ack, 7'h01);
    bus.vld_user = '0;

    // Resend mid-stream.
    bus.vld_user = 7'b0001001;
    for (int k = 0; k < 2; k++) begin
      pl[0] = $urandom; pl[3] = $urandom;
      cycle();
    end
    bus.resend = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("resend_ack", seen_ack, 7'd0);
      chk("resend_dout", bus.dout, 49'd0);
    end
    bus.resend = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pl[0] = $urandom; pl[3] = $urandom;
      cycle();
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) pl[i] = $urandom;
      bus.vld_user    = 7'($urandom);
      bus.bft_ready   = ($urandom_range(0, 3) != 0);
      bus.resend      = ($urandom_range(0, 15) == 0);
      bus.credit_vld  = ($urandom_range(0, 7) == 0);
      bus.credit_port = 4'($urandom_range(0, 15));
      bus.cfg_we      = ($urandom_range(0, 7) == 0);
      bus.cfg_port    = 4'($urandom_range(0, 15));
      bus.cfg_leaf    = 5'($urandom);
      bus.cfg_dport   = 4'($urandom);
      cycle();
    end
    bus.resend     = 1'b0;
    bus.bft_ready  = 1'b1;
    bus.credit_vld = 1'b0;
    bus.cfg_we     = 1'b0;

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < N; i++) cfg(i, i + 2, i);
    bus.vld_user = 7'h7F;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) pl[i] = $urandom;
      cycle();
    end
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_dout", bus.dout, 49'd0);
    chk("async_rst_ack", bus.ack_user, 7'd0);
    chk("async_rst_grant_idx", bus.grant_idx, 4'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("unconfigured_ack", seen_ack, 7'd0);
    end
    cfg(4, 12, 6);
    pl[4] = 32'hCAFE_F00D;
    cycle();
    chk("reconfig_ack", seen_ack, 7'h10);
    chk("reconfig_pkt", bus.dout, {1'b1, 5'd12, 4'd6, 7'd0, 32'hCAFEF00D});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
